// File: rtl/ehgu_clk2phase_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ehgu_clk2phase_monitor_if                                      |
// | Purpose  : Bundles the control inputs and measurement/flag outputs of     |
// |            the two-phase clock monitor.                                   |
// | Ports    : en, clkp0, clkp1, err_clr        (master -> slave)             |
// |            meas_valid, p0_high, gap01, p1_high, gap10, period, meas_cnt,  |
// |            overlap_err, order_err, gap_err  (slave -> master)             |
// |            master = stimulus/consumer side, slave = the monitor.          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface ehgu_clk2phase_monitor_if #(
  parameter int CW = 16
);

  // Control and observed clocks
  logic          en;
  logic          clkp0;
  logic          clkp1;
  logic          err_clr;

  // Measurement results
  logic          meas_valid;
  logic [CW-1:0] p0_high;
  logic [CW-1:0] gap01;
  logic [CW-1:0] p1_high;
  logic [CW-1:0] gap10;
  logic [CW-1:0] period;
  logic [31:0]   meas_cnt;

  // Sticky error flags
  logic          overlap_err;
  logic          order_err;
  logic          gap_err;

  modport master (
    output en, clkp0, clkp1, err_clr,
    input  meas_valid, p0_high, gap01, p1_high, gap10, period, meas_cnt,
    input  overlap_err, order_err, gap_err
  );

  modport slave (
    input  en, clkp0, clkp1, err_clr,
    output meas_valid, p0_high, gap01, p1_high, gap10, period, meas_cnt,
    output overlap_err, order_err, gap_err
  );

endinterface
`default_nettype wire

// File: rtl/ehgu_clk2phase_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ehgu_clk2phase_monitor                                         |
// | Purpose  : Oversamples a two-phase non-overlapping clock pair and, per    |
// |            full cycle, measures phase-0 high, gap 0->1, phase-1 high,     |
// |            gap 1->0 and the total period in sample-clock cycles. Raises   |
// |            sticky flags for overlap, phase-order and short-gap faults.    |
// | Ports    : clk  - sample clock (faster than 2x fastest phase toggle)      |
// |            rst  - synchronous, active-high reset                          |
// |            mon  - slave modport: en, clkp0, clkp1, err_clr in;            |
// |                   meas_valid, p0_high, gap01, p1_high, gap10, period,     |
// |                   meas_cnt, overlap_err, order_err, gap_err out           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module ehgu_clk2phase_monitor #(
  parameter int CW          = 16,
  parameter int MIN_GAP     = 1,
  parameter int SYNC_STAGES = 2
) (
  input wire                      clk,
  input wire                      rst,
  ehgu_clk2phase_monitor_if.slave mon
);

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_P0_HI = 3'd1,
    ST_GAP01 = 3'd2,
    ST_P1_HI = 3'd3,
    ST_GAP10 = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW:0]   MIN_GAP_W = (CW+1)'(MIN_GAP);

  // Saturating increment shared by all working counters
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic gap_short(input logic [CW-1:0] v);
    return ({1'b0, v} < MIN_GAP_W);
  endfunction

  // ---------------------------------------------------------------- state
  state_t                 state_q, state_d;

  logic [SYNC_STAGES-1:0] sync0_q, sync0_d;
  logic [SYNC_STAGES-1:0] sync1_q, sync1_d;
  logic                   s0_dly_q, s0_dly_d;
  logic                   s1_dly_q, s1_dly_d;

  logic [CW-1:0]          wk_p0_q, wk_p0_d;
  logic [CW-1:0]          wk_g01_q, wk_g01_d;
  logic [CW-1:0]          wk_p1_q, wk_p1_d;
  logic [CW-1:0]          wk_g10_q, wk_g10_d;

  logic                   meas_valid_q, meas_valid_d;
  logic [CW-1:0]          p0_high_q, p0_high_d;
  logic [CW-1:0]          gap01_q, gap01_d;
  logic [CW-1:0]          p1_high_q, p1_high_d;
  logic [CW-1:0]          gap10_q, gap10_d;
  logic [CW-1:0]          period_q, period_d;
  logic [31:0]            meas_cnt_q, meas_cnt_d;

  logic                   overlap_err_q, overlap_err_d;
  logic                   order_err_q, order_err_d;
  logic                   gap_err_q, gap_err_d;

  // ------------------------------------------------------ combinational
  logic                   s0, s1, rise0;
  logic [CW-1:0]          w_g10_fin;
  logic [CW+1:0]          w_period_sum;
  logic [CW-1:0]          w_period_sat;

  logic                   set_ovl, set_ord, set_gap;
  logic                   clear_wk, start_p0, close_cyc;

  assign s0    = sync0_q[SYNC_STAGES-1];
  assign s1    = sync1_q[SYNC_STAGES-1];
  assign rise0 = s0 & ~s0_dly_q;

  // A cycle closes either from GAP10 (real gap) or directly from P1_HI
  // when clkp1 falls in the same sample clkp0 rises (zero-length gap).
  assign w_g10_fin    = (state_q == ST_GAP10) ? wk_g10_q : '0;
  assign w_period_sum = {2'b00, wk_p0_q} + {2'b00, wk_g01_q}
                      + {2'b00, wk_p1_q} + {2'b00, w_g10_fin};
  assign w_period_sat = (w_period_sum > {2'b00, CNT_MAX}) ? CNT_MAX
                                                          : w_period_sum[CW-1:0];

  always_comb begin
    sync0_d       = {sync0_q[SYNC_STAGES-2:0], mon.clkp0};
    sync1_d       = {sync1_q[SYNC_STAGES-2:0], mon.clkp1};
    s0_dly_d      = s0;
    s1_dly_d      = s1;

    state_d       = state_q;
    wk_p0_d       = wk_p0_q;
    wk_g01_d      = wk_g01_q;
    wk_p1_d       = wk_p1_q;
    wk_g10_d      = wk_g10_q;

    meas_valid_d  = 1'b0;
    p0_high_d     = p0_high_q;
    gap01_d       = gap01_q;
    p1_high_d     = p1_high_q;
    gap10_d       = gap10_q;
    period_d      = period_q;
    meas_cnt_d    = meas_cnt_q;

    set_ovl       = 1'b0;
    set_ord       = 1'b0;
    set_gap       = 1'b0;
    clear_wk      = 1'b0;
    start_p0      = 1'b0;
    close_cyc     = 1'b0;

    if (!mon.en) begin
      state_d  = ST_SYNC;
      clear_wk = 1'b1;
    end else if (s0 && s1) begin
      // Overlap overrides every state and discards the cycle in progress
      set_ovl  = 1'b1;
      state_d  = ST_SYNC;
      clear_wk = 1'b1;
    end else begin
      // Past this point at most one phase is high in the current sample,
      // so in a high state a low level means that phase just fell, and in
      // a gap state a high level means that phase just rose.
      case (state_q)
        ST_SYNC: begin
          clear_wk = 1'b1;
          if (rise0) begin
            start_p0 = 1'b1;
          end
        end

        ST_P0_HI: begin
          if (s0) begin
            wk_p0_d = sat_inc(wk_p0_q);
          end else if (s1) begin
            state_d  = ST_P1_HI;
            wk_g01_d = '0;
            wk_p1_d  = CNT_ONE;
            set_gap  = gap_short('0);
          end else begin
            state_d  = ST_GAP01;
            wk_g01_d = CNT_ONE;
          end
        end

        ST_GAP01: begin
          if (s1) begin
            state_d = ST_P1_HI;
            wk_p1_d = CNT_ONE;
            set_gap = gap_short(wk_g01_q);
          end else if (s0) begin
            // clkp0 rose again: restart measuring from this new rise
            set_ord  = 1'b1;
            start_p0 = 1'b1;
          end else begin
            wk_g01_d = sat_inc(wk_g01_q);
          end
        end

        ST_P1_HI: begin
          if (s1) begin
            wk_p1_d = sat_inc(wk_p1_q);
          end else if (s0) begin
            close_cyc = 1'b1;
            start_p0  = 1'b1;
            set_gap   = gap_short('0);
          end else begin
            state_d  = ST_GAP10;
            wk_g10_d = CNT_ONE;
          end
        end

        ST_GAP10: begin
          if (s0) begin
            close_cyc = 1'b1;
            start_p0  = 1'b1;
            set_gap   = gap_short(wk_g10_q);
          end else if (s1) begin
            set_ord  = 1'b1;
            state_d  = ST_SYNC;
            clear_wk = 1'b1;
          end else begin
            wk_g10_d = sat_inc(wk_g10_q);
          end
        end

        default: begin
          state_d  = ST_SYNC;
          clear_wk = 1'b1;
        end
      endcase
    end

    if (clear_wk) begin
      wk_p0_d  = '0;
      wk_g01_d = '0;
      wk_p1_d  = '0;
      wk_g10_d = '0;
    end

    // Every clkp0 rise that is accepted starts a fresh cycle
    if (start_p0) begin
      state_d  = ST_P0_HI;
      wk_p0_d  = CNT_ONE;
      wk_g01_d = '0;
      wk_p1_d  = '0;
      wk_g10_d = '0;
    end

    if (close_cyc) begin
      meas_valid_d = 1'b1;
      p0_high_d    = wk_p0_q;
      gap01_d      = wk_g01_q;
      p1_high_d    = wk_p1_q;
      gap10_d      = w_g10_fin;
      period_d     = w_period_sat;
      meas_cnt_d   = meas_cnt_q + 32'd1;
    end

    // Sticky flags: a set in the same cycle as err_clr takes priority
    overlap_err_d = set_ovl | (overlap_err_q & ~mon.err_clr);
    order_err_d   = set_ord | (order_err_q   & ~mon.err_clr);
    gap_err_d     = set_gap | (gap_err_q     & ~mon.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      sync0_q       <= '0;
      sync1_q       <= '0;
      s0_dly_q      <= 1'b0;
      s1_dly_q      <= 1'b0;
      wk_p0_q       <= '0;
      wk_g01_q      <= '0;
      wk_p1_q       <= '0;
      wk_g10_q      <= '0;
      meas_valid_q  <= 1'b0;
      p0_high_q     <= '0;
      gap01_q       <= '0;
      p1_high_q     <= '0;
      gap10_q       <= '0;
      period_q      <= '0;
      meas_cnt_q    <= '0;
      overlap_err_q <= 1'b0;
      order_err_q   <= 1'b0;
      gap_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync0_q       <= sync0_d;
      sync1_q       <= sync1_d;
      s0_dly_q      <= s0_dly_d;
      s1_dly_q      <= s1_dly_d;
      wk_p0_q       <= wk_p0_d;
      wk_g01_q      <= wk_g01_d;
      wk_p1_q       <= wk_p1_d;
      wk_g10_q      <= wk_g10_d;
      meas_valid_q  <= meas_valid_d;
      p0_high_q     <= p0_high_d;
      gap01_q       <= gap01_d;
      p1_high_q     <= p1_high_d;
      gap10_q       <= gap10_d;
      period_q      <= period_d;
      meas_cnt_q    <= meas_cnt_d;
      overlap_err_q <= overlap_err_d;
      order_err_q   <= order_err_d;
      gap_err_q     <= gap_err_d;
    end
  end

  assign mon.meas_valid  = meas_valid_q;
  assign mon.p0_high     = p0_high_q;
  assign mon.gap01       = gap01_q;
  assign mon.p1_high     = p1_high_q;
  assign mon.gap10       = gap10_q;
  assign mon.period      = period_q;
  assign mon.meas_cnt    = meas_cnt_q;
  assign mon.overlap_err = overlap_err_q;
  assign mon.order_err   = order_err_q;
  assign mon.gap_err     = gap_err_q;

  // s1_dly_q mirrors s0_dly_q for symmetry; only the clkp0 rise is needed
  // as an explicit edge, so fold it into a harmless reduction.
  logic unused_s1_dly;
  assign unused_s1_dly = s1_dly_q;

endmodule
`default_nettype wire

// File: tb/tb_ehgu_clk2phase_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ehgu_clk2phase_monitor                                      |
// | Purpose  : Self-checking bench for ehgu_clk2phase_monitor. Drives        |
// |            directed and randomized two-phase waveforms and compares      |
// |            reported measurements and flags with a cycle-level model.     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_ehgu_clk2phase_monitor;

  localparam int CW_T      = 8;
  localparam int MIN_GAP_T = 3;
  localparam int MAXV      = (1 << CW_T) - 1;

  typedef struct packed {
    logic [CW_T-1:0] p0;
    logic [CW_T-1:0] g01;
    logic [CW_T-1:0] p1;
    logic [CW_T-1:0] g10;
    logic [CW_T-1:0] per;
  } rep_t;

  // kind: 0 = clean cycle, 1 = overlapping phases, 2 = clkp0 pulses twice
  typedef struct {
    int kind;
    int h0;
    int g01;
    int h1;
    int g10;
    int d;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ehgu_clk2phase_monitor_if #(.CW(CW_T)) mon_if ();

  ehgu_clk2phase_monitor #(
    .CW          (CW_T),
    .MIN_GAP     (MIN_GAP_T),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  rep_t        obs_q[$];
  rep_t        exp_q[$];
  rep_t        last_exp = '0;
  logic [31:0] m_cnt = '0;
  logic        m_ovl = 1'b0;
  logic        m_ord = 1'b0;
  logic        m_gap = 1'b0;

  always @(negedge clk) begin
    if (!rst && mon_if.meas_valid) begin
      obs_q.push_back({mon_if.p0_high, mon_if.gap01, mon_if.p1_high,
                       mon_if.gap10, mon_if.period});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW_T-1:0] sat(input int v);
    return (v > MAXV) ? CW_T'(MAXV) : CW_T'(v);
  endfunction

  function automatic int rand_len();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(240, 300));
    return int'($urandom_range(1, 60));
  endfunction

  function automatic cyc_t gen_cycle(input int mode);
    cyc_t c;
    c.kind = 0; c.h0 = 40; c.g01 = 10; c.h1 = 40; c.g10 = 10; c.d = 0;
    if (mode != 0) begin
      c.kind = (mode == 2) ? int'($urandom_range(0, 5)) : 0;
      if (c.kind > 3) c.kind = c.kind - 3;  // 4 -> overlap, 5 -> order
      if (c.kind > 2) c.kind = 0;
      c.h0  = rand_len();
      c.h1  = rand_len();
      c.g01 = int'($urandom_range(0, 12));
      c.g10 = int'($urandom_range(0, 12));
      if (c.kind == 1) begin
        c.h0  = int'($urandom_range(4, 40));
        c.d   = int'($urandom_range(1, c.h0 - 1));
        c.h1  = int'($urandom_range(c.d + 1, 40));
        c.g10 = int'($urandom_range(MIN_GAP_T, 12));
      end else if (c.kind == 2) begin
        c.h0  = int'($urandom_range(1, 40));
        c.g01 = int'($urandom_range(MIN_GAP_T, 12));
      end
    end
    return c;
  endfunction

  // Expected outcome of one cycle, judged from its shape alone
  task automatic model_cycle(input cyc_t c);
    rep_t r;
    if (c.kind == 0) begin
      r.p0  = sat(c.h0);
      r.g01 = sat(c.g01);
      r.p1  = sat(c.h1);
      r.g10 = sat(c.g10);
      r.per = sat(c.h0 + c.g01 + c.h1 + c.g10);
      exp_q.push_back(r);
      last_exp = r;
      m_cnt    = m_cnt + 32'd1;
      if (c.g01 < MIN_GAP_T || c.g10 < MIN_GAP_T) m_gap = 1'b1;
    end else if (c.kind == 1) begin
      m_ovl = 1'b1;
    end else begin
      m_ord = 1'b1;
    end
  endtask

  task automatic seg(input logic b0, input logic b1, input int n);
    mon_if.clkp0 = b0;
    mon_if.clkp1 = b1;
    if (n > 0) repeat (n) @(negedge clk);
  endtask

  task automatic drive_cycle(input cyc_t c);
    if (c.kind == 0) begin
      seg(1'b1, 1'b0, c.h0);
      seg(1'b0, 1'b0, c.g01);
      seg(1'b0, 1'b1, c.h1);
      seg(1'b0, 1'b0, c.g10);
    end else if (c.kind == 1) begin
      seg(1'b1, 1'b0, c.h0 - c.d);
      seg(1'b1, 1'b1, c.d);
      seg(1'b0, 1'b1, c.h1 - c.d);
      seg(1'b0, 1'b0, c.g10);
    end else begin
      seg(1'b1, 1'b0, c.h0);
      seg(1'b0, 1'b0, c.g01);
    end
  endtask

  task automatic check_flags(input string tag, input logic o, input logic r, input logic g);
    check({tag, ".overlap_err"}, 32'(mon_if.overlap_err), 32'(o));
    check({tag, ".order_err"},   32'(mon_if.order_err),   32'(r));
    check({tag, ".gap_err"},     32'(mon_if.gap_err),     32'(g));
  endtask

  task automatic run_block(input string tag, input int mode, input int n);
    cyc_t c;
    int   m;
    for (int i = 0; i < n; i++) begin
      c = gen_cycle(mode);
      model_cycle(c);
      drive_cycle(c);
    end
    // Final clkp0 rise closes the last cycle; en low then parks the FSM
    seg(1'b1, 1'b0, 6);
    mon_if.en = 1'b0;
    seg(1'b0, 1'b0, 6);
    mon_if.en = 1'b1;
    seg(1'b0, 1'b0, 2);

    check({tag, ".reports"}, 32'(obs_q.size()), 32'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.p0_high[%0d]", tag, i), 32'(obs_q[i].p0),  32'(exp_q[i].p0));
      check($sformatf("%s.gap01[%0d]",   tag, i), 32'(obs_q[i].g01), 32'(exp_q[i].g01));
      check($sformatf("%s.p1_high[%0d]", tag, i), 32'(obs_q[i].p1),  32'(exp_q[i].p1));
      check($sformatf("%s.gap10[%0d]",   tag, i), 32'(obs_q[i].g10), 32'(exp_q[i].g10));
      check($sformatf("%s.period[%0d]",  tag, i), 32'(obs_q[i].per), 32'(exp_q[i].per));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, ".meas_cnt"}, mon_if.meas_cnt, m_cnt);
    check_flags(tag, m_ovl, m_ord, m_gap);

    mon_if.err_clr = 1'b1;
    @(negedge clk);
    mon_if.err_clr = 1'b0;
    @(negedge clk);
    m_ovl = 1'b0; m_ord = 1'b0; m_gap = 1'b0;
    check_flags({tag, ".clr"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".meas_valid"}, 32'(mon_if.meas_valid), 32'd0);
    check({tag, ".p0_high"},    32'(mon_if.p0_high),    32'd0);
    check({tag, ".gap01"},      32'(mon_if.gap01),      32'd0);
    check({tag, ".p1_high"},    32'(mon_if.p1_high),    32'd0);
    check({tag, ".gap10"},      32'(mon_if.gap10),      32'd0);
    check({tag, ".period"},     32'(mon_if.period),     32'd0);
    check({tag, ".meas_cnt"},   mon_if.meas_cnt,        32'd0);
    check_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mon_if.en      = 1'b0;
    mon_if.clkp0   = 1'b0;
    mon_if.clkp1   = 1'b0;
    mon_if.err_clr = 1'b0;
    rst            = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    mon_if.en = 1'b1;
    seg(1'b0, 1'b0, 4);

    // 40/10/40/10 reference waveform
    run_block("clean", 0, 5);
    // Random clean cycles, some long enough to saturate
    run_block("rand_clean", 1, 12);
    // Mix of clean, overlapping and mis-ordered cycles
    run_block("rand_mix", 2, 16);

    // Overlap sampled while err_clr is held: the set must win
    mon_if.err_clr = 1'b1;
    seg(1'b1, 1'b1, 6);
    check("set_wins.overlap_err", 32'(mon_if.overlap_err), 32'd1);
    seg(1'b0, 1'b0, 5);
    check("clr_after.overlap_err", 32'(mon_if.overlap_err), 32'd0);
    mon_if.err_clr = 1'b0;
    seg(1'b0, 1'b0, 2);

    // Monitor disabled while the phases run, including an overlap
    mon_if.en = 1'b0;
    seg(1'b1, 1'b0, 8);
    seg(1'b1, 1'b1, 6);
    seg(1'b0, 1'b1, 8);
    seg(1'b0, 1'b0, 8);
    check("en_hold.pulses",      32'(obs_q.size()),      32'd0);
    check("en_hold.meas_cnt",    mon_if.meas_cnt,        m_cnt);
    check("en_hold.p0_high",     32'(mon_if.p0_high),    32'(last_exp.p0));
    check("en_hold.gap10",       32'(mon_if.gap10),      32'(last_exp.g10));
    check("en_hold.period",      32'(mon_if.period),     32'(last_exp.per));
    check("en_hold.overlap_err", 32'(mon_if.overlap_err), 32'd0);
    mon_if.en = 1'b1;
    seg(1'b0, 1'b0, 4);

    run_block("after_en", 2, 12);

    // Reset while phase 1 is high discards the partial cycle
    seg(1'b1, 1'b0, 20);
    seg(1'b0, 1'b0, 5);
    seg(1'b0, 1'b1, 10);
    rst = 1'b1;
    seg(1'b0, 1'b1, 2);
    rst = 1'b0;
    check_all_zero("mid_rst");
    m_cnt    = '0;
    last_exp = '0;
    obs_q.delete();
    exp_q.delete();
    seg(1'b0, 1'b1, 5);
    seg(1'b0, 1'b0, 5);
    run_block("post_rst", 1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
